// File: rtl/left_shift_rot_32_pipe.sv
// Five-stage pipelined 32-bit left shifter/rotator with a valid/ready handshake.
// Stages shift by 16, 8, 4, 2, 1 in that order; a stalled output freezes the whole pipe.
module left_shift_rot_32_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in,
    input  logic [4:0]  select,
    input  logic        rotate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    // One conditional stage: shift by a fixed n, wrapping the top bits back in when rotating.
    function automatic logic [31:0] shl_stage(input logic [31:0] d, input int unsigned n,
                                              input logic en, input logic rot);
        logic [31:0] shifted;
        logic [31:0] wrapped;
        shifted = d << n;
        wrapped = rot ? (d >> (32 - n)) : 32'h0;
        return en ? (shifted | wrapped) : d;
    endfunction

    logic        stall;
    logic [4:0]  valid_q, valid_d;
    logic [31:0] data_q [5];
    logic [31:0] data_d [5];
    logic [3:0]  sel1_q, sel1_d;
    logic [2:0]  sel2_q, sel2_d;
    logic [1:0]  sel3_q, sel3_d;
    logic        sel4_q, sel4_d;
    logic [3:0]  rot_q, rot_d;

    assign stall     = valid_q[4] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[4];
    assign out       = data_q[4];

    // Only the select bits still needed downstream travel with each stage.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        sel3_d  = sel3_q;
        sel4_d  = sel4_q;
        rot_d   = rot_q;
        if (!stall) begin
            valid_d   = {valid_q[3:0], in_valid && in_ready};
            data_d[0] = shl_stage(in, 16, select[4], rotate);
            sel1_d    = select[3:0];
            rot_d[0]  = rotate;
            data_d[1] = shl_stage(data_q[0], 8, sel1_q[3], rot_q[0]);
            sel2_d    = sel1_q[2:0];
            rot_d[1]  = rot_q[0];
            data_d[2] = shl_stage(data_q[1], 4, sel2_q[2], rot_q[1]);
            sel3_d    = sel2_q[1:0];
            rot_d[2]  = rot_q[1];
            data_d[3] = shl_stage(data_q[2], 2, sel3_q[1], rot_q[2]);
            sel4_d    = sel3_q[0];
            rot_d[3]  = rot_q[2];
            data_d[4] = shl_stage(data_q[3], 1, sel4_q, rot_q[3]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 5'b0;
            data_q  <= '{default: 32'h0};
            sel1_q  <= 4'b0;
            sel2_q  <= 3'b0;
            sel3_q  <= 2'b0;
            sel4_q  <= 1'b0;
            rot_q   <= 4'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            sel3_q  <= sel3_d;
            sel4_q  <= sel4_d;
            rot_q   <= rot_d;
        end
    end

endmodule
